// File: rtl/inst_fetch_pkg.sv
// Shared instruction-field masks and fetch FSM encodings, used identically
// by the decoder and the fetch unit.
package inst_fetch_pkg;

    localparam logic [15:0] ONE_ARG_MASK = 16'hC000;
    localparam logic [15:0] ONE_ARG_VAL  = 16'h8000;
    localparam logic [15:0] SRC_MASK     = 16'h0600;
    localparam logic [15:0] SRC_DATA     = 16'h0200;

    typedef enum logic [1:0] {
        FETCH_HI   = 2'd0,
        FETCH_LO   = 2'd1,
        FETCH_DATA = 2'd2,
        ISSUE      = 2'd3
    } fetch_state_t;

    // One-arg instruction whose source is the trailing data byte.
    function automatic logic needs_data(input logic [15:0] i);
        return ((i & ONE_ARG_MASK) == ONE_ARG_VAL) && ((i & SRC_MASK) == SRC_DATA);
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles 16-bit instructions plus optional data byte from
// byte-wide program memory and holds them for the execute stage until ack.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_rd,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ready,
    input  logic [7:0]      mem_rdata,
    output logic [15:0]     inst,
    output logic [7:0]      data,
    output logic            en,
    input  logic            ack,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] pc
);

    fetch_state_t    state, state_nxt;
    logic [PC_W-1:0] pc_r;
    logic [15:0]     inst_r;
    logic [7:0]      data_r;
    logic            byte_taken;

    assign mem_rd     = (state != ISSUE) && !rst;
    assign mem_addr   = pc_r;
    assign en         = (state == ISSUE);
    assign pc         = pc_r;
    assign inst       = inst_r;
    assign data       = data_r;
    assign byte_taken = mem_rd && mem_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_HI: begin
                if (byte_taken) state_nxt = FETCH_LO;
            end
            FETCH_LO: begin
                // Decide on the fully assembled word, including the byte arriving now.
                if (byte_taken)
                    state_nxt = needs_data({inst_r[15:8], mem_rdata}) ? FETCH_DATA : ISSUE;
            end
            FETCH_DATA: begin
                if (byte_taken) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (ack) state_nxt = FETCH_HI;
            end
            default: state_nxt = FETCH_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH_HI;
            pc_r   <= RESET_PC;
            inst_r <= '0;
            data_r <= '0;
        end else begin
            state <= state_nxt;
            if (byte_taken) pc_r <= pc_r + PC_W'(1);
            case (state)
                FETCH_HI: begin
                    if (byte_taken) begin
                        inst_r[15:8] <= mem_rdata;
                        data_r       <= '0;
                    end
                end
                FETCH_LO: begin
                    if (byte_taken) inst_r[7:0] <= mem_rdata;
                end
                FETCH_DATA: begin
                    if (byte_taken) data_r <= mem_rdata;
                end
                ISSUE: begin
                    // pc already points past the instruction; only a taken branch moves it.
                    if (ack && jump) pc_r <= jump_target;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: byte memory model, handshake stalls,
// ack/jump handling, PC wrap and reset during a data fetch.
module tb_inst_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_rd;
    logic [7:0] mem_addr;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic [15:0] inst;
    logic [7:0] data;
    logic       en;
    logic       ack;
    logic       jump;
    logic [7:0] jump_target;
    logic [7:0] pc;

    logic [7:0] mem [0:255];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    inst_fetch #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .inst        (inst),
        .data        (data),
        .en          (en),
        .ack         (ack),
        .jump        (jump),
        .jump_target (jump_target),
        .pc          (pc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_issue(input string tag, input logic [15:0] ei, input logic [7:0] ed,
                             input logic [7:0] ep);
        chk({tag, "_en"},   32'(en),   32'd1);
        chk({tag, "_inst"}, 32'(inst), 32'(ei));
        chk({tag, "_data"}, 32'(data), 32'(ed));
        chk({tag, "_pc"},   32'(pc),   32'(ep));
        chk({tag, "_rd"},   32'(mem_rd), 32'd0);
    endtask

    task automatic do_ack(input logic j, input logic [7:0] tgt);
        ack = 1'b1; jump = j; jump_target = tgt;
        step();
        ack = 1'b0; jump = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h00; mem[8'h01] = 8'h08;
        mem[8'h02] = 8'h82; mem[8'h03] = 8'h00; mem[8'h04] = 8'h5A;
        mem[8'h40] = 8'h83; mem[8'h41] = 8'h00; mem[8'h42] = 8'h77;
        mem[8'h43] = 8'h84; mem[8'h44] = 8'h00;
        mem[8'h45] = 8'h81; mem[8'h46] = 8'h00;
        mem[8'h47] = 8'h00; mem[8'h48] = 8'h11;
        mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h22;
        mem[8'h50] = 8'h82; mem[8'h51] = 8'h00; mem[8'h52] = 8'h99;

        rst = 1'b1; mem_ready = 1'b1; ack = 1'b0; jump = 1'b0; jump_target = 8'h00;
        step();
        chk("rst_rd_low", 32'(mem_rd), 32'd0);
        step();
        chk("rst_pc",   32'(pc),   32'h00);
        chk("rst_en",   32'(en),   32'd0);
        chk("rst_inst", 32'(inst), 32'h0000);
        chk("rst_data", 32'(data), 32'h00);
        rst = 1'b0;
        #1;
        chk("rel_rd", 32'(mem_rd), 32'd1);

        // 2-byte instruction: en in the third cycle
        step();
        chk("i1_lo_en", 32'(en), 32'd0);
        step();
        chk_issue("i1", 16'h0008, 8'h00, 8'h02);
        do_ack(1'b0, 8'h00);
        chk("i1_en_drop", 32'(en), 32'd0);

        // 3-byte instruction with data byte
        step(); step();
        chk("i2_data_en", 32'(en), 32'd0);
        chk("i2_data_addr", 32'(mem_addr), 32'h04);
        step();
        chk_issue("i2", 16'h8200, 8'h5A, 8'h05);

        // hold without ack, stray jump ignored
        for (int c = 0; c < 10; c++) begin
            jump = (c == 4); jump_target = 8'h33;
            step();
            jump = 1'b0;
            if (c == 4 || c == 9) chk_issue("hold", 16'h8200, 8'h5A, 8'h05);
        end

        do_ack(1'b1, 8'h40);
        chk("jmp_addr", 32'(mem_addr), 32'h40);
        chk("jmp_rd",   32'(mem_rd),   32'd1);

        // data-hi source fetches third byte
        step(); step(); step();
        chk_issue("i8300", 16'h8300, 8'h77, 8'h43);
        do_ack(1'b0, 8'h00);
        // ram source: no data byte
        step(); step();
        chk_issue("i8400", 16'h8400, 8'h00, 8'h45);
        do_ack(1'b0, 8'h00);
        // const-hi source: no data byte
        step(); step();
        chk_issue("i8100", 16'h8100, 8'h00, 8'h47);
        do_ack(1'b0, 8'h00);

        // memory stall in FETCH_LO
        step();
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("stall_rd",   32'(mem_rd),   32'd1);
            chk("stall_addr", 32'(mem_addr), 32'h48);
            chk("stall_pc",   32'(pc),       32'h48);
            chk("stall_en",   32'(en),       32'd0);
        end
        mem_ready = 1'b1;
        step();
        chk_issue("stall", 16'h0011, 8'h00, 8'h49);

        // wrap across 2^PC_W
        do_ack(1'b1, 8'hFE);
        chk("wrap_addr0", 32'(mem_addr), 32'hFE);
        step();
        chk("wrap_addr1", 32'(mem_addr), 32'hFF);
        step();
        chk_issue("wrap", 16'h0022, 8'h00, 8'h00);
        do_ack(1'b0, 8'h00);
        chk("wrap_next", 32'(mem_addr), 32'h00);

        // reset during FETCH_DATA
        step(); step();
        chk_issue("pre", 16'h0008, 8'h00, 8'h02);
        do_ack(1'b1, 8'h50);
        step(); step();
        chk("fd_addr", 32'(mem_addr), 32'h52);
        chk("fd_rd",   32'(mem_rd),   32'd1);
        rst = 1'b1;
        #1;
        chk("fd_rst_rd", 32'(mem_rd), 32'd0);
        step();
        chk("fd_pc",   32'(pc),   32'h00);
        chk("fd_en",   32'(en),   32'd0);
        chk("fd_inst", 32'(inst), 32'h0000);
        chk("fd_data", 32'(data), 32'h00);
        chk("fd_rd2",  32'(mem_rd), 32'd0);
        rst = 1'b0;
        #1;
        chk("fd_rel_rd", 32'(mem_rd), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
